// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine: buffers COLS columns of A and COLS elements
// of b, then runs a skewed MAC schedule over ROWS lanes into wrapping accumulators.
module matvec_engine #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned ACC_W  = 24,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  acc_keep,
    input  logic                  abort,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ROWS*DW-1:0]    a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [DW-1:0]         b_data,
    output logic                  busy,
    output logic                  done,
    output logic                  y_valid,
    output logic [ROWS*ACC_W-1:0] y
);

    localparam int unsigned CNT_W = $clog2(COLS + 1);
    localparam int unsigned IDX_W = $clog2(COLS);
    localparam int unsigned CYC_W = $clog2(COLS + ROWS);
    localparam logic [CNT_W-1:0] COLS_C   = CNT_W'(COLS);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(COLS + ROWS - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0]   b_cnt_q, b_cnt_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [DW-1:0]      a_buf_q [ROWS][COLS];
    logic [DW-1:0]      a_buf_d [ROWS][COLS];
    logic [DW-1:0]      b_buf_q [COLS];
    logic [DW-1:0]      b_buf_d [COLS];
    logic [ACC_W-1:0]   acc_q [ROWS];
    logic [ACC_W-1:0]   acc_d [ROWS];
    logic               a_ready_q, a_ready_d;
    logic               b_ready_q, b_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               y_valid_q, y_valid_d;

    // Full-width product extended to the accumulator width per operand signedness.
    function automatic logic [ACC_W-1:0] mac_term(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0]        uprod;
        logic signed [2*DW-1:0] sprod;
        uprod = (2*DW)'(a) * (2*DW)'(b);
        sprod = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
        if (SIGNED) return ACC_W'(sprod);
        else        return ACC_W'(uprod);
    endfunction

    // Next-state, stream capture, skewed MAC schedule and status flags.
    always_comb begin
        state_d   = state_q;
        a_cnt_d   = a_cnt_q;
        b_cnt_d   = b_cnt_q;
        cyc_d     = cyc_q;
        a_buf_d   = a_buf_q;
        b_buf_d   = b_buf_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        y_valid_d = y_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    a_cnt_d   = '0;
                    b_cnt_d   = '0;
                    y_valid_d = 1'b0;
                    if (!acc_keep) begin
                        for (int r = 0; r < int'(ROWS); r++) acc_d[r] = '0;
                    end
                end
            end
            ST_LOAD: begin
                if (a_valid && a_ready_q) begin
                    for (int r = 0; r < int'(ROWS); r++) begin
                        a_buf_d[r][IDX_W'(a_cnt_q)] = a_data[r*DW +: DW];
                    end
                    a_cnt_d = a_cnt_q + CNT_W'(1);
                end
                if (b_valid && b_ready_q) begin
                    b_buf_d[IDX_W'(b_cnt_q)] = b_data;
                    b_cnt_d = b_cnt_q + CNT_W'(1);
                end
                if (a_cnt_d == COLS_C && b_cnt_d == COLS_C) begin
                    state_d = ST_COMPUTE;
                    cyc_d   = '0;
                end
            end
            ST_COMPUTE: begin
                // Lane r consumes column (cyc - r) so lanes start one cycle apart.
                for (int r = 0; r < int'(ROWS); r++) begin
                    if (int'(cyc_q) >= r && int'(cyc_q) - r < int'(COLS)) begin
                        acc_d[r] = acc_q[r] + mac_term(a_buf_q[r][IDX_W'(int'(cyc_q) - r)],
                                                       b_buf_q[IDX_W'(int'(cyc_q) - r)]);
                    end
                end
                if (cyc_q == LAST_CYC) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    y_valid_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Cancel overrides everything, including a same-cycle start; accumulators keep their value.
        if (abort) begin
            state_d   = ST_IDLE;
            a_cnt_d   = '0;
            b_cnt_d   = '0;
            cyc_d     = '0;
            acc_d     = acc_q;
            done_d    = 1'b0;
            y_valid_d = 1'b0;
        end

        busy_d    = (state_d != ST_IDLE);
        a_ready_d = (state_d == ST_LOAD) && (a_cnt_d < COLS_C);
        b_ready_d = (state_d == ST_LOAD) && (b_cnt_d < COLS_C);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
            cyc_q     <= '0;
            a_buf_q   <= '{default: '0};
            b_buf_q   <= '{default: '0};
            acc_q     <= '{default: '0};
            a_ready_q <= 1'b0;
            b_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_cnt_q   <= a_cnt_d;
            b_cnt_q   <= b_cnt_d;
            cyc_q     <= cyc_d;
            a_buf_q   <= a_buf_d;
            b_buf_q   <= b_buf_d;
            acc_q     <= acc_d;
            a_ready_q <= a_ready_d;
            b_ready_q <= b_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            y_valid_q <= y_valid_d;
        end
    end

    // Results come straight from the accumulators.
    always_comb begin
        y = '0;
        for (int r = 0; r < int'(ROWS); r++) y[r*ACC_W +: ACC_W] = acc_q[r];
    end

    assign a_ready = a_ready_q;
    assign b_ready = b_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Bench for matvec_engine: directed table of jobs, randomized jobs against a
// plain-arithmetic model, plus abort / reset / start-abort sequences.
module tb_matvec_engine;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n, start, acc_keep, abort;
    logic a_valid, b_valid;
    logic [N*8-1:0] a_data;
    logic [7:0] b_data;
    logic a_ready_u, b_ready_u, busy_u, done_u, y_valid_u;
    logic a_ready_s, b_ready_s, busy_s, done_s, y_valid_s;
    logic [N*24-1:0] y_u, y_s;

    always #5 clk = ~clk;

    matvec_engine #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_keep(acc_keep), .abort(abort),
        .a_valid(a_valid), .a_ready(a_ready_u), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready_u), .b_data(b_data),
        .busy(busy_u), .done(done_u), .y_valid(y_valid_u), .y(y_u));

    matvec_engine #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_keep(acc_keep), .abort(abort),
        .a_valid(a_valid), .a_ready(a_ready_s), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready_s), .b_data(b_data),
        .busy(busy_s), .done(done_s), .y_valid(y_valid_s), .y(y_s));

    typedef struct {
        int              pat;    // 0 identity/b=1..8, 1 all 0xFF, 2 all 0x80, 3 all 1
        bit              keep;
        int              mode;   // 0 back-to-back, 1 random gaps, 2 b first then a every other cycle
        logic [N*24-1:0] exp_u;
        logic [N*24-1:0] exp_s;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [7:0] mat [N][N];
    logic [7:0] vec [N];
    longint m_u [N];
    longint m_s [N];
    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [N*24-1:0] uniform(input logic [23:0] v);
        logic [N*24-1:0] o;
        for (int r = 0; r < N; r++) o[r*24 +: 24] = v;
        return o;
    endfunction

    function automatic logic [N*24-1:0] ramp();
        logic [N*24-1:0] o;
        for (int r = 0; r < N; r++) o[r*24 +: 24] = 24'(r + 1);
        return o;
    endfunction

    task automatic fill_pattern(input int pat);
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                case (pat)
                    0: mat[r][k] = (r == k) ? 8'd1 : 8'd0;
                    1: mat[r][k] = 8'hFF;
                    2: mat[r][k] = 8'h80;
                    default: mat[r][k] = 8'd1;
                endcase
            end
            case (pat)
                0: vec[r] = 8'(r + 1);
                1: vec[r] = 8'hFF;
                2: vec[r] = 8'h80;
                default: vec[r] = 8'd1;
            endcase
        end
    endtask

    // y[r] = (keep ? y[r] : 0) + sum_k A[r][k]*b[k], modulo 2^24.
    task automatic model_job(input bit keep, output logic [N*24-1:0] eu, output logic [N*24-1:0] es);
        for (int r = 0; r < N; r++) begin
            if (!keep) begin
                m_u[r] = 0;
                m_s[r] = 0;
            end
            for (int k = 0; k < N; k++) begin
                m_u[r] = m_u[r] + longint'(mat[r][k]) * longint'(vec[k]);
                m_s[r] = m_s[r] + longint'($signed(mat[r][k])) * longint'($signed(vec[k]));
            end
            m_u[r] = m_u[r] & 64'hFFFFFF;
            m_s[r] = m_s[r] & 64'hFFFFFF;
            eu[r*24 +: 24] = 24'(m_u[r]);
            es[r*24 +: 24] = 24'(m_s[r]);
        end
    endtask

    task automatic set_model(input logic [N*24-1:0] eu, input logic [N*24-1:0] es);
        for (int r = 0; r < N; r++) begin
            m_u[r] = longint'(eu[r*24 +: 24]);
            m_s[r] = longint'(es[r*24 +: 24]);
        end
    endtask

    task automatic start_job(input bit keep);
        start    = 1'b1;
        acc_keep = keep;
        @(negedge clk);
        start    = 1'b0;
        acc_keep = 1'b0;
    endtask

    // Feed both streams; returns at the negedge after the last beat is accepted.
    task automatic load_streams(input int mode);
        int  ai = 0;
        int  bi = 0;
        int  guard = 0;
        bit  av, bv, ar, br;
        while ((ai < N || bi < N) && guard < 300) begin
            case (mode)
                0: begin av = (ai < N); bv = (bi < N); end
                1: begin av = (ai < N) && ($urandom_range(0, 1) == 1);
                         bv = (bi < N) && ($urandom_range(0, 1) == 1); end
                default: begin bv = 1'b1; av = (bi >= N) && (guard % 2 == 0); end
            endcase
            if (mode == 2 && bi >= N) chk("b_ready_stall", 64'(b_ready_u), 64'd0);
            for (int r = 0; r < N; r++) a_data[r*8 +: 8] = (ai < N) ? mat[r][ai] : 8'($urandom);
            b_data  = (bi < N) ? vec[bi] : 8'($urandom);
            a_valid = av;
            b_valid = bv;
            ar = a_ready_u;
            br = b_ready_u;
            @(posedge clk);
            if (av && ar) ai++;
            if (bv && br) bi++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 300) chk("load_timeout", 64'd1, 64'd0);
        chk("a_ready_after_load", 64'(a_ready_u), 64'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [N*24-1:0] eu, input logic [N*24-1:0] es);
        int cnt = 0;
        while (cnt < 60) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (done_u) break;
        end
        chk({name, "_latency"}, 64'(cnt), 64'd15);
        chk({name, "_y_valid"}, 64'(y_valid_u), 64'd1);
        chk({name, "_busy"}, 64'(busy_u), 64'd0);
        for (int r = 0; r < N; r++) begin
            chk($sformatf("%s_yu%0d", name, r), 64'(y_u[r*24 +: 24]), 64'(eu[r*24 +: 24]));
            chk($sformatf("%s_ys%0d", name, r), 64'(y_s[r*24 +: 24]), 64'(es[r*24 +: 24]));
        end
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(done_u), 64'd0);
        chk({name, "_y_hold"}, 64'(y_u[23:0]), 64'(eu[23:0]));
    endtask

    task automatic run_table_entry(input int i);
        fill_pattern(tbl[i].pat);
        start_job(tbl[i].keep);
        load_streams(tbl[i].mode);
        wait_done($sformatf("tbl%0d", i), tbl[i].exp_u, tbl[i].exp_s);
        set_model(tbl[i].exp_u, tbl[i].exp_s);
    endtask

    initial begin
        logic [N*24-1:0] eu, es;
        bool_seen_t: begin end
        tbl[0] = '{pat: 0, keep: 1'b0, mode: 0, exp_u: ramp(), exp_s: ramp()};
        tbl[1] = '{pat: 1, keep: 1'b0, mode: 0, exp_u: uniform(24'd520200), exp_s: uniform(24'd8)};
        tbl[2] = '{pat: 2, keep: 1'b0, mode: 0, exp_u: uniform(24'd131072), exp_s: uniform(24'd131072)};
        tbl[3] = '{pat: 3, keep: 1'b0, mode: 0, exp_u: uniform(24'd8), exp_s: uniform(24'd8)};
        tbl[4] = '{pat: 3, keep: 1'b1, mode: 1, exp_u: uniform(24'd16), exp_s: uniform(24'd16)};
        tbl[5] = '{pat: 0, keep: 1'b0, mode: 2, exp_u: ramp(), exp_s: ramp()};
        for (int r = 0; r < N; r++) begin m_u[r] = 0; m_s[r] = 0; end

        rst_n = 1'b0; start = 1'b0; acc_keep = 1'b0; abort = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_u), 64'd0);
        chk("rst_ready", 64'({a_ready_u, b_ready_u}), 64'd0);
        chk("rst_done_yv", 64'({done_u, y_valid_u}), 64'd0);
        chk("rst_y", 64'(|y_u), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_table_entry(i);

        // Randomized jobs against the arithmetic model.
        for (int j = 0; j < 6; j++) begin
            bit keep;
            int mode;
            keep = ($urandom_range(0, 2) == 0);
            mode = int'($urandom_range(0, 1));
            for (int r = 0; r < N; r++) begin
                for (int k = 0; k < N; k++) mat[r][k] = 8'($urandom);
                vec[r] = 8'($urandom);
            end
            model_job(keep, eu, es);
            start_job(keep);
            load_streams(mode);
            wait_done($sformatf("rnd%0d", j), eu, es);
        end

        // Abort during compute cycle 3, then a fresh job.
        fill_pattern(3);
        start_job(1'b0);
        load_streams(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy_u), 64'd0);
        chk("abort_y_valid", 64'(y_valid_u), 64'd0);
        chk("abort_done", 64'(done_u), 64'd0);
        begin
            bit seen = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (done_u || busy_u) seen = 1'b1;
            end
            chk("abort_quiet", 64'(seen), 64'd0);
        end
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) mat[r][k] = 8'($urandom);
            vec[r] = 8'($urandom);
        end
        model_job(1'b0, eu, es);
        start_job(1'b0);
        load_streams(1);
        wait_done("post_abort", eu, es);

        // Start and abort in the same cycle: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy_u), 64'd0);
        chk("start_abort_ready", 64'(a_ready_u), 64'd0);
        chk("start_abort_y_valid", 64'(y_valid_u), 64'd0);

        // Asynchronous reset mid-load.
        fill_pattern(1);
        start_job(1'b0);
        a_valid = 1'b1; b_valid = 1'b1;
        for (int r = 0; r < N; r++) a_data[r*8 +: 8] = 8'hFF;
        b_data = 8'hFF;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_u), 64'd0);
        chk("arst_ready", 64'({a_ready_u, b_ready_u}), 64'd0);
        chk("arst_done_yv", 64'({done_u, y_valid_u}), 64'd0);
        chk("arst_y", 64'(|y_u), 64'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < N; r++) begin m_u[r] = 0; m_s[r] = 0; end
        run_table_entry(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
